alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 28 ++
 rtl/issue_fifo.sv | 60 ++++++
 rtl/alu_issue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue slice: widths, FSM encoding and the
// layout of one queued instruction.
package alu_issue_pkg;

  localparam int DATA_W     = 18;
  localparam int REG_AW     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int SEL_W      = 2;

  // Sequencer state encoding (2 bits, one state per pipeline step).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPER = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  // One queued instruction, MSB first: {sel, rd, ra, rb, mov, imm}.
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              mov;
    logic [DATA_W-1:0] imm;
  } issue_entry_t;

  localparam int ENTRY_W = $bits(issue_entry_t);  // 30 bits

endpackage

// File: rtl/issue_fifo.sv
// In-order instruction queue: synchronous push/pop, occupancy counter to
// tell full from empty, pointers wrapping modulo DEPTH.
module issue_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write port.
  // NOTE: storage has no reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update; push and pop on one edge both apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Serialized ALU issue stage: queues instructions, reads operands into the
// registered ALU inputs, captures the ALU (or immediate) result and writes it
// back to an 8-entry register file whose R0 is hard-wired to zero.
module alu_issue #(
  parameter int DATA_W     = alu_issue_pkg::DATA_W,
  parameter int REG_AW     = alu_issue_pkg::REG_AW,
  parameter int FIFO_DEPTH = alu_issue_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_ra,
  input  logic [REG_AW-1:0] in_rb,
  input  logic              in_mov,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_z,
  output logic              wr_done,
  output logic              flag_z,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import alu_issue_pkg::*;

  localparam int NUM_REGS = 1 << REG_AW;

  issue_entry_t      push_entry;
  issue_entry_t      head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  logic [1:0]        state;
  logic [REG_AW-1:0] rd_q;
  logic              mov_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] result;
  logic              zf;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;

  assign push_entry = '{sel: in_sel, rd: in_rd, ra: in_ra, rb: in_rb,
                        mov: in_mov, imm: in_imm};
  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  issue_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register-file read ports: operands for the head entry and the debug port.
  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    ra_val   = (head.ra == '0) ? '0 : regs[head.ra];
    rb_val   = (head.rb == '0) ? '0 : regs[head.rb];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

  // Sequencer: pop -> operands, capture result, write back, return to idle.
  // NOTE: state is updated with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rd_q    <= '0;
      mov_q   <= 1'b0;
      imm_q   <= '0;
      result  <= '0;
      zf      <= 1'b0;
      flag_z  <= 1'b0;
      wr_done <= 1'b0;
      // The register file is architecturally visible, so it is cleared too.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state   <= ST_OPER;
            alu_a   <= ra_val;
            alu_b   <= rb_val;
            alu_sel <= head.sel;
            rd_q    <= head.rd;
            mov_q   <= head.mov;
            imm_q   <= head.imm;
          end
        end
        ST_OPER: begin
          state  <= ST_EXEC;
          result <= mov_q ? imm_q : alu_c;
          zf     <= mov_q ? (imm_q == '0) : alu_z;
        end
        ST_EXEC: begin
          state   <= ST_WB;
          if (rd_q != '0) regs[rd_q] <= result;
          flag_z  <= zf;
          wr_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
